bcd_scan_counter: RTL

- Parametrised N-digit BCD up/down counter with an integrated multiplexed 7-segment scan driver. It is the next generation of the two-digit 0-99 display counter.
- Everything runs in the single clk_50mhz domain. The block derives count ticks and scan steps as one-cycle enables, not as generated clocks.
- It adds direction control, synchronous clear, display hold and a wrap flag.
- It sits between the board clock/switch inputs and the digit-select/segment pins.

---
 rtl/bcd_scan_counter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter driving a multiplexed active-low 7-segment display; ticks and scan steps are clock enables.
// Define BCD_SCAN_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module bcd_scan_counter #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100,
    parameter int SCAN_HZ = 1000,
    parameter int DIGITS  = 4
) (
    input  logic                  clk_50mhz,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  hold,
    output logic [DIGITS-1:0]     sel,
    output logic [6:0]            seg,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int TW       = $clog2(TICK_DIV);
    localparam int SW       = $clog2(SCAN_DIV);
    localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW       = 4 * DIGITS;

    logic [TW-1:0]     tdiv_q, tdiv_d;
    logic [SW-1:0]     sdiv_q, sdiv_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     disp_q, disp_d;
    logic              wrap_q, wrap_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [6:0]        seg_q, seg_d;

    logic              tick;
    logic              scan_step;
    logic [CW-1:0]     count_step;
    logic              carry;
    logic [3:0]        dig;
    logic [3:0]        cur_dig;
    logic              blank;
    logic              zero_run;

    function automatic logic [6:0] seg_enc(input logic [3:0] v);
        case (v)
            4'd0:    seg_enc = 7'b0000001;
            4'd1:    seg_enc = 7'b1001111;
            4'd2:    seg_enc = 7'b0010010;
            4'd3:    seg_enc = 7'b0000110;
            4'd4:    seg_enc = 7'b1001100;
            4'd5:    seg_enc = 7'b0100100;
            4'd6:    seg_enc = 7'b0100000;
            4'd7:    seg_enc = 7'b0001111;
            4'd8:    seg_enc = 7'b0000000;
            4'd9:    seg_enc = 7'b0001100;
            default: seg_enc = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        tick      = (tdiv_q == TW'(TICK_DIV - 1));
        scan_step = (sdiv_q == SW'(SCAN_DIV - 1));
        tdiv_d    = tick ? '0 : tdiv_q + TW'(1);
        sdiv_d    = scan_step ? '0 : sdiv_q + SW'(1);
        idx_d     = idx_q;
        if (scan_step) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Ripple the +1/-1 through the digits; carry out of the top digit is a full-range wrap.
    always_comb begin
        count_step = count_q;
        carry      = 1'b1;
        dig        = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = count_q[4*k +: 4];
            if (carry) begin
                if (up_dn) begin
                    if (dig == 4'd9) begin
                        count_step[4*k +: 4] = 4'd0;
                    end else begin
                        count_step[4*k +: 4] = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        count_step[4*k +: 4] = 4'd9;
                    end else begin
                        count_step[4*k +: 4] = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end

        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (tick && en) begin
            count_d = count_step;
            wrap_d  = carry;
        end
        disp_d = hold ? disp_q : count_q;
    end

    // Digit select and segment pattern are both derived from the same index so they move together.
    always_comb begin
        cur_dig  = '0;
        blank    = 1'b0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (disp_q[4*k +: 4] == 4'd0);
            if (idx_q == IW'(k)) begin
                cur_dig = disp_q[4*k +: 4];
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
                blank = (k > 0) && zero_run;
`endif
            end
        end
        sel_d = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_q);
        seg_d = blank ? 7'b1111111 : seg_enc(cur_dig);
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            tdiv_q  <= '0;
            sdiv_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
            disp_q  <= '0;
            wrap_q  <= 1'b0;
            sel_q   <= ~{{(DIGITS-1){1'b0}}, 1'b1};
            seg_q   <= 7'b0000001;
        end else begin
            tdiv_q  <= tdiv_d;
            sdiv_q  <= sdiv_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            disp_q  <= disp_d;
            wrap_q  <= wrap_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
        end
    end

    assign sel       = sel_q;
    assign seg       = seg_q;
    assign count_bcd = count_q;
    assign wrap      = wrap_q;

endmodule
